// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: fixed priority to the pipeline (P) with a
// starvation override for the long-latency unit (L). Optional bypass: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_valid,
  input  logic [4:0]      p_rd,
  input  logic [XLEN-1:0] p_data,
  output logic            p_ready,
  input  logic            l_valid,
  input  logic [4:0]      l_rd,
  input  logic [XLEN-1:0] l_data,
  output logic            l_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            l_forced
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [4:0]      byp_rs1,
  input  logic [4:0]      byp_rs2,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data
`endif
);

  // Handshake: a write transfers on a cycle where valid && ready; the requester
  // holds valid/rd/data until then. ready depends only on valids, state and rst.
  typedef enum logic {
    PRI_P = 1'b0,
    PRI_L = 1'b1
  } state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;
  logic              grant_p, grant_l;

  always_comb begin
    grant_p    = 1'b0;
    grant_l    = 1'b0;
    state_d    = state_q;
    wait_cnt_d = 4'd0;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;

    if (!rst) begin
      case (state_q)
        PRI_L: begin
          if (l_valid)      grant_l = 1'b1;
          else if (p_valid) grant_p = 1'b1;
        end
        default: begin
          if (p_valid)      grant_p = 1'b1;
          else if (l_valid) grant_l = 1'b1;
        end
      endcase
    end

    // L denied while still asking: count toward the override, saturating.
    if (l_valid && !grant_l) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
    end

    case (state_q)
      PRI_L:   if (grant_l || !l_valid) state_d = PRI_P;
      default: if (wait_cnt_d == MAX_WAIT_C) state_d = PRI_L;
    endcase

    // x0 writes are accepted but never reach the register file.
    if (grant_p && (p_rd != 5'd0)) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = p_rd;
      rf_data_d = p_data;
    end else if (grant_l && (l_rd != 5'd0)) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = l_rd;
      rf_data_d = l_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PRI_P;
      wait_cnt_q <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign p_ready  = grant_p;
  assign l_ready  = grant_l;
  assign l_forced = (state_q == PRI_L) && grant_l && p_valid;
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_data  = rf_data_q;

`ifdef RF_WB_BYPASS_EN
  // Exposes the write the register file commits at the next edge to decode now.
  assign byp_hit1 = rf_we_q && (rf_rd_q == byp_rs1) && (rf_rd_q != 5'd0);
  assign byp_hit2 = rf_we_q && (rf_rd_q == byp_rs2) && (rf_rd_q != 5'd0);
  assign byp_data = rf_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors, a request-level reference model
// checked every cycle, and literal checks at key points of each scenario.
module tb_rf_wb_arbiter;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            p_valid = 1'b0;
  logic [4:0]      p_rd = 5'd0;
  logic [XLEN-1:0] p_data = '0;
  logic            p_ready;
  logic            l_valid = 1'b0;
  logic [4:0]      l_rd = 5'd0;
  logic [XLEN-1:0] l_data = '0;
  logic            l_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            l_forced;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]      byp_rs1 = 5'd0;
  logic [4:0]      byp_rs2 = 5'd0;
  logic            byp_hit1;
  logic            byp_hit2;
  logic [XLEN-1:0] byp_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
    .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data), .l_ready(l_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .l_forced(l_forced)
`ifdef RF_WB_BYPASS_EN
    ,
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1),
    .byp_hit2(byp_hit2), .byp_data(byp_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_denied = consecutive cycles L has been refused; reaching MAX_WAIT gives
  // L precedence for the following cycle.
  int              m_denied;
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;

  function automatic logic exp_p_grant();
    return !rst && p_valid && !(l_valid && m_denied == MAX_WAIT);
  endfunction

  function automatic logic exp_l_grant();
    return !rst && l_valid && (m_denied == MAX_WAIT || !p_valid);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_denied <= 0;
      m_we     <= 1'b0;
      m_rd     <= 5'd0;
      m_data   <= '0;
    end else begin
      m_we <= 1'b0;
      if (exp_p_grant() && p_rd != 0) begin
        m_we <= 1'b1; m_rd <= p_rd; m_data <= p_data;
      end else if (exp_l_grant() && l_rd != 0) begin
        m_we <= 1'b1; m_rd <= l_rd; m_data <= l_data;
      end
      if (l_valid && !exp_l_grant())
        m_denied <= (m_denied + 1 > MAX_WAIT) ? MAX_WAIT : m_denied + 1;
      else
        m_denied <= 0;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    check("p_ready", {31'd0, p_ready}, {31'd0, exp_p_grant()});
    check("l_ready", {31'd0, l_ready}, {31'd0, exp_l_grant()});
    check("l_forced", {31'd0, l_forced}, {31'd0, exp_l_grant() && p_valid});
    check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    if (m_we || rst) begin
      check("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
      check("rf_data", rf_data, m_data);
    end
`ifdef RF_WB_BYPASS_EN
    check("byp_hit1", {31'd0, byp_hit1}, {31'd0, m_we && m_rd == byp_rs1 && m_rd != 0});
    check("byp_hit2", {31'd0, byp_hit2}, {31'd0, m_we && m_rd == byp_rs2 && m_rd != 0});
    if (m_we) check("byp_data", byp_data, m_data);
`endif
  end

  // ---------------- driver ----------------
  // Drives one cycle's inputs just after the rising edge, returns 2 time units
  // later so combinational outputs can be checked.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk);
    #1;
    p_valid = pv; p_rd = prd; p_data = pd;
    l_valid = lv; l_rd = lrd; l_data = ld;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset with both requesters asserting: readies must stay low.
    p_valid = 1'b1; p_rd = 5'd2; l_valid = 1'b1; l_rd = 5'd3;
    #2;
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    check("rst_rf_data", rf_data, 32'd0);
    check("rst_p_ready", {31'd0, p_ready}, 32'd0);
    check("rst_l_ready", {31'd0, l_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    p_valid = 1'b0; l_valid = 1'b0;
    idle();

    // Single P write.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("single_p_ready", {31'd0, p_ready}, 32'd1);
    idle();
    check("single_rf_we", {31'd0, rf_we}, 32'd1);
    check("single_rf_rd", {27'd0, rf_rd}, 32'd5);
    check("single_rf_data", rf_data, 32'hDEADBEEF);
    idle();
    check("single_rf_we_off", {31'd0, rf_we}, 32'd0);

    // Contention: P wins 4 cycles, L forced on the 5th, P again on the 6th.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'(i + 1), 32'h100 + i, 1'b1, 5'd9, 32'h9999_0009);
      check("cont_p_ready", {31'd0, p_ready}, 32'd1);
      check("cont_l_ready", {31'd0, l_ready}, 32'd0);
    end
    step(1'b1, 5'd6, 32'h106, 1'b1, 5'd9, 32'h9999_0009);
    check("cont_force_l_ready", {31'd0, l_ready}, 32'd1);
    check("cont_force_p_ready", {31'd0, p_ready}, 32'd0);
    check("cont_forced", {31'd0, l_forced}, 32'd1);
    step(1'b1, 5'd6, 32'h106, 1'b0, 5'd0, 32'd0);
    check("cont_after_p_ready", {31'd0, p_ready}, 32'd1);
    check("cont_after_rf_rd", {27'd0, rf_rd}, 32'd9);
    check("cont_after_rf_data", rf_data, 32'h9999_0009);
    idle();

    // x0 write from L is accepted but not written.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    check("x0_l_ready", {31'd0, l_ready}, 32'd1);
    idle();
    check("x0_rf_we", {31'd0, rf_we}, 32'd0);

    // Same destination from both: acceptance order decides.
    step(1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hBBBB);
    check("waw_l_ready", {31'd0, l_ready}, 32'd1);
    check("waw_first_data", rf_data, 32'hAAAA);
    idle();
    check("waw_second_data", rf_data, 32'hBBBB);
    idle();

    // Async reset between the output load and the register-file edge.
    step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    idle();
    check("rstmid_rf_we_before", {31'd0, rf_we}, 32'd1);
    #1;
    p_valid = 1'b1; p_rd = 5'd10; p_data = 32'hA0;
    l_valid = 1'b1; l_rd = 5'd11; l_data = 32'hB0;
    rst = 1'b1;
    #1;
    check("rstmid_rf_we", {31'd0, rf_we}, 32'd0);
    check("rstmid_p_ready", {31'd0, p_ready}, 32'd0);
    check("rstmid_l_ready", {31'd0, l_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rstmid_pri_p", {31'd0, p_ready}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd10, 32'hA0 + i, 1'b1, 5'd11, 32'hB0);
    idle();

    // L withdrawal after 3 denied cycles clears its wait count.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd12, 32'hC0 + i, 1'b1, 5'd13, 32'hD0);
    step(1'b1, 5'd12, 32'hC3, 1'b0, 5'd0, 32'd0);
    check("wd_p_ready", {31'd0, p_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'd12, 32'hE0 + i, 1'b1, 5'd13, 32'hD1);
      if (i == 3) check("wd_fourth_p", {31'd0, p_ready}, 32'd1);
      if (i == 4) check("wd_fifth_l", {31'd0, l_ready}, 32'd1);
    end
    idle();

`ifdef RF_WB_BYPASS_EN
    step(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    p_valid = 1'b0; byp_rs1 = 5'd7; byp_rs2 = 5'd0;
    #1;
    check("byp_hit1_lit", {31'd0, byp_hit1}, 32'd1);
    check("byp_hit2_lit", {31'd0, byp_hit2}, 32'd0);
    check("byp_data_lit", byp_data, 32'hA5A5A5A5);
    idle();
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
